// File: rtl/ws2812_frame_scheduler_pkg.sv
// Shared types and default timing for the WS2812 frame scheduler.
// GRB pixel width and the state encoding are common to the top and its testbench.
package ws2812_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StSend,
        StLatch
    } state_e;

    localparam int unsigned GRB_BITS = 24;
    localparam int unsigned CNT_W    = 12;

    // Defaults assume a 12 MHz clock
    localparam int unsigned DEF_NUM_LEDS = 10;
    localparam int unsigned DEF_T0H_CYC  = 4;
    localparam int unsigned DEF_T1H_CYC  = 8;
    localparam int unsigned DEF_TBIT_CYC = 15;
    localparam int unsigned DEF_TRST_CYC = 960;

endpackage

// File: rtl/ws2812_frame_scheduler_if.sv
// Pixel fetch handshake between the frame scheduler (master) and the pixel source (slave).
interface ws2812_frame_scheduler_if #(
    parameter int unsigned IDX_W = 4
);
    logic             pix_req;
    logic [IDX_W-1:0] pix_addr;
    logic             pix_valid;
    logic [23:0]      pix_grb;

    modport master (
        output pix_req,
        output pix_addr,
        input  pix_valid,
        input  pix_grb
    );

    modport slave (
        input  pix_req,
        input  pix_addr,
        output pix_valid,
        output pix_grb
    );

endinterface

// File: rtl/ws2812_frame_scheduler_led_bit_counter.sv
// Count of bits transmitted in the current frame; cleared at frame start.
module led_bit_counter
    import ws2812_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Saturates rather than wrapping so a mis-sized frame cannot alias to a short one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Fetches NUM_LEDS GRB pixels, serialises them MSB-first with WS2812 bit timing on dout,
// then holds the line low for the latch gap. A one-entry shadow buffer prefetches pixels.
module ws2812_frame_scheduler
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS = DEF_NUM_LEDS,
    parameter int unsigned T0H_CYC  = DEF_T0H_CYC,
    parameter int unsigned T1H_CYC  = DEF_T1H_CYC,
    parameter int unsigned TBIT_CYC = DEF_TBIT_CYC,
    parameter int unsigned TRST_CYC = DEF_TRST_CYC
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            underrun,
    output logic                            dout,
    ws2812_frame_scheduler_if.master        pix
);

    localparam int unsigned IDX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned NIDX_W     = $clog2(NUM_LEDS + 1);
    localparam int unsigned PH_W       = $clog2(TBIT_CYC);
    localparam int unsigned GAP_W      = $clog2(TRST_CYC);
    localparam int unsigned FRAME_BITS = NUM_LEDS * GRB_BITS;

    localparam logic [PH_W-1:0]   T0H_P    = PH_W'(T0H_CYC);
    localparam logic [PH_W-1:0]   T1H_P    = PH_W'(T1H_CYC);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(TBIT_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TRST_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_PRE  = GAP_W'(TRST_CYC - 2);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [4:0]        BIT_LAST = 5'(GRB_BITS - 1);
    localparam logic [NIDX_W-1:0] NIDX_END = NIDX_W'(NUM_LEDS);

    state_e                state_q;
    logic [PH_W-1:0]       phase_q;
    logic [GAP_W-1:0]      gap_q;
    logic [4:0]            bit_idx_q;
    logic [GRB_BITS-1:0]   shift_q;
    logic [GRB_BITS-1:0]   shadow_q;
    logic                  shadow_full_q;
    logic [NIDX_W-1:0]     next_idx_q;
    logic                  pix_req_q;
    logic [IDX_W-1:0]      pix_addr_q;
    logic                  busy_q;
    logic                  frame_done_q;
    logic                  underrun_q;
    logic                  dout_q;

    logic [CNT_W-1:0]      bit_count;
    logic                  cnt_clr;
    logic                  bit_end;
    logic                  last_bit;
    logic                  pix_end;
    logic                  hs;
    logic [PH_W-1:0]       phase_nxt;
    logic [PH_W-1:0]       high_len;

    always_comb begin
        cnt_clr   = (state_q == StIdle) && start;
        bit_end   = (state_q == StSend) && (phase_q == PH_LAST);
        last_bit  = bit_end && (bit_count == CNT_LAST);
        pix_end   = bit_end && (bit_idx_q == BIT_LAST);
        hs        = pix_req_q && pix.pix_valid;
        phase_nxt = phase_q + 1'b1;
        high_len  = shift_q[GRB_BITS-1] ? T1H_P : T0H_P;
    end

    led_bit_counter u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (bit_end),
        .count (bit_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            phase_q       <= '0;
            gap_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            next_idx_q    <= '0;
            pix_req_q     <= 1'b0;
            pix_addr_q    <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            underrun_q    <= 1'b0;
            dout_q        <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    dout_q <= 1'b0;
                    if (start) begin
                        state_q       <= StFetch;
                        busy_q        <= 1'b1;
                        pix_req_q     <= 1'b1;
                        pix_addr_q    <= '0;
                        next_idx_q    <= '0;
                        shadow_full_q <= 1'b0;
                    end
                end

                StFetch: begin
                    if (hs) begin
                        shift_q    <= pix.pix_grb;
                        pix_req_q  <= 1'b0;
                        next_idx_q <= NIDX_W'(1);
                        phase_q    <= '0;
                        bit_idx_q  <= '0;
                        dout_q     <= 1'b1;
                        state_q    <= StSend;
                    end
                end

                StSend: begin
                    // Prefetch into the shadow buffer while the current pixel shifts out
                    if (hs) begin
                        shadow_q      <= pix.pix_grb;
                        shadow_full_q <= 1'b1;
                        pix_req_q     <= 1'b0;
                        next_idx_q    <= next_idx_q + 1'b1;
                    end else if (!pix_req_q && !shadow_full_q && (next_idx_q < NIDX_END)) begin
                        pix_req_q  <= 1'b1;
                        pix_addr_q <= next_idx_q[IDX_W-1:0];
                    end

                    if (bit_end) begin
                        phase_q <= '0;
                        if (last_bit) begin
                            state_q <= StLatch;
                            gap_q   <= '0;
                            dout_q  <= 1'b0;
                        end else if (pix_end) begin
                            bit_idx_q <= '0;
                            if (shadow_full_q) begin
                                shift_q       <= shadow_q;
                                shadow_full_q <= 1'b0;
                                dout_q        <= 1'b1;
                            end else begin
                                // Pixel late: abort the frame but still run the latch gap
                                underrun_q <= 1'b1;
                                pix_req_q  <= 1'b0;
                                state_q    <= StLatch;
                                gap_q      <= '0;
                                dout_q     <= 1'b0;
                            end
                        end else begin
                            shift_q   <= {shift_q[GRB_BITS-2:0], 1'b0};
                            bit_idx_q <= bit_idx_q + 1'b1;
                            dout_q    <= 1'b1;
                        end
                    end else begin
                        phase_q <= phase_nxt;
                        dout_q  <= (phase_nxt < high_len);
                    end
                end

                StLatch: begin
                    dout_q <= 1'b0;
                    if (gap_q == GAP_LAST) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                        if (gap_q == GAP_PRE) begin
                            frame_done_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign underrun     = underrun_q;
    assign dout         = dout_q;
    assign pix.pix_req  = pix_req_q;
    assign pix.pix_addr = pix_addr_q;

endmodule
